// File: rtl/sccb_reader.sv
// ---------------------------------------------------------------------------
// sccb_reader
//   SCCB master that reads back one 8-bit camera register.
//   It runs a 2-phase write cycle (device ID + sub-address) and then a
//   2-phase read cycle (device ID + data), and returns the byte it read.
//   It shares the scl/sda pair with the register writer.
//
//   Transaction: START, ID<<1|0, SUB, STOP, GAP, START, ID<<1|1, DATA(NACK),
//   STOP. That is 41 slots of 4*CLK_DIV cycles each.
//
// Parameters
//   CLK_DIV  clk cycles per quarter-bit slot (legal range 2..1023)
//   DEV_ID   default 7-bit device ID, used when dev_sel = 0
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   rst        asynchronous, active-high reset; abandons the bus at once
//   start      request pulse; sampled only while idle
//   dev_sel    0: use DEV_ID, 1: use the dev_id input
//   dev_id     alternative 7-bit device ID
//   reg_addr   register sub-address to read
//   busy       high while a transaction is in progress
//   done       1-cycle pulse at the end of a transaction
//   err        ACK-check failure of the current/last transaction
//   rd_data    last byte read; held until the next successful read
//   scl        SCCB clock, push-pull
//   sda        SCCB data, open-drain (driven 0 or high-Z only)
//   debug_out  {state, quarter, bit_cnt, 4'h0, latched reg_addr, rd_data}
//
// Optional feature
//   Define SCCB_ACK_CHECK_EN to sample the 9th bit of every transmitted
//   byte. A high (missing) ACK ends the transaction through a STOP slot
//   with err = 1, and rd_data is left unchanged. When the macro is not
//   defined, the 9th bits are ignored and err is tied to 0.
// ---------------------------------------------------------------------------
module sccb_reader #(
  parameter int unsigned CLK_DIV = 32,
  parameter logic [6:0]  DEV_ID  = 7'h21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dev_sel,
  input  logic [6:0]  dev_id,
  input  logic [7:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rd_data,
  output logic        scl,
  inout  wire         sda,
  output logic [31:0] debug_out
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START1  = 4'd1,
    TX_IDW  = 4'd2,
    TX_SUB  = 4'd3,
    STOP1   = 4'd4,
    GAP     = 4'd5,
    START2  = 4'd6,
    TX_IDR  = 4'd7,
    RX_DATA = 4'd8,
    STOP2   = 4'd9
  } state_t;

  localparam int DIV_W = 10;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter;
  logic [3:0]       bit_cnt;
  logic [6:0]       id_lat;
  logic [7:0]       addr_lat;
  logic [7:0]       rx_shift;
  logic [7:0]       tx_byte;
  logic             tx_bit;
  logic             sda_low;
  logic             slot_end;
  logic             byte_end;
  logic             sample_tick;
  logic             is_byte;
  logic             accept;
  logic             ack_fail;
  logic [3:0]       state_code;

  assign accept      = (state == IDLE) && start;
  assign slot_end    = (div_cnt == DIV_LAST) && (quarter == 2'd3);
  assign byte_end    = slot_end && (bit_cnt == 4'd8);
  // First clk of q3: SCL has been high for a whole quarter, so SDA is settled.
  assign sample_tick = (div_cnt == '0) && (quarter == 2'd3);
  assign is_byte     = (state == TX_IDW) || (state == TX_SUB) ||
                       (state == TX_IDR) || (state == RX_DATA);
  assign busy        = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Byte currently on the wire, and its bit for this slot (MSB first)
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      TX_IDW:  tx_byte = {id_lat, 1'b0};
      TX_SUB:  tx_byte = addr_lat;
      TX_IDR:  tx_byte = {id_lat, 1'b1};
      default: tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[3'd7 - bit_cnt[2:0]];
  end

  // Next state and bus levels
  always_comb begin
    state_nx = state;
    scl      = 1'b1;
    sda_low  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = START1;
      end
      START1, START2: begin
        // SDA falls in q2 while SCL is still high, then SCL drops in q3
        scl     = (quarter != 2'd3);
        sda_low = quarter[1];
        if (slot_end) state_nx = (state == START1) ? TX_IDW : TX_IDR;
      end
      TX_IDW: begin
        scl     = quarter[1];
        sda_low = (bit_cnt != 4'd8) && !tx_bit;
        if (byte_end) state_nx = ack_fail ? STOP2 : TX_SUB;
      end
      TX_SUB: begin
        scl     = quarter[1];
        sda_low = (bit_cnt != 4'd8) && !tx_bit;
        if (byte_end) state_nx = ack_fail ? STOP2 : STOP1;
      end
      TX_IDR: begin
        scl     = quarter[1];
        sda_low = (bit_cnt != 4'd8) && !tx_bit;
        if (byte_end) state_nx = ack_fail ? STOP2 : RX_DATA;
      end
      RX_DATA: begin
        // SDA stays released for all 9 bits; the 9th one is the master NACK
        scl = quarter[1];
        if (byte_end) state_nx = STOP2;
      end
      STOP1, STOP2: begin
        // SDA is held low from q0 and released in q3 while SCL is high
        scl     = (quarter != 2'd0);
        sda_low = (quarter != 2'd3);
        if (slot_end) state_nx = (state == STOP1) ? GAP : IDLE;
      end
      GAP: begin
        if (slot_end) state_nx = START2;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Timing base: divider -> quarter -> bit. All counters rest at 0 while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      quarter <= 2'd0;
      bit_cnt <= 4'd0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      quarter <= 2'd0;
      bit_cnt <= 4'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      quarter <= quarter + 2'd1;
      if (quarter == 2'd3) begin
        // bit_cnt wraps after the 9th bit, so every byte state starts at 0
        bit_cnt <= (is_byte && (bit_cnt != 4'd8)) ? bit_cnt + 4'd1 : 4'd0;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Request latch and receive shifter
  always_ff @(posedge clk) begin
    if (accept) begin
      id_lat   <= dev_sel ? dev_id : DEV_ID;
      addr_lat <= reg_addr;
    end
    if ((state == RX_DATA) && sample_tick && (bit_cnt != 4'd8)) begin
      rx_shift <= {rx_shift[6:0], sda};
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  logic ack_bit;
  logic err_q;
  logic is_tx;

  assign is_tx = (state == TX_IDW) || (state == TX_SUB) || (state == TX_IDR);

  always_ff @(posedge clk) begin
    if (is_tx && sample_tick && (bit_cnt == 4'd8)) begin
      ack_bit <= sda;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (is_tx && byte_end && ack_bit) begin
      err_q <= 1'b1;
    end
  end

  assign ack_fail = ack_bit;
  assign err      = err_q;
`else
  assign ack_fail = 1'b0;
  assign err      = 1'b0;
`endif

  // Completion: done and the read byte appear on the edge that returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      done <= (state == STOP2) && slot_end;
      if ((state == STOP2) && slot_end && !err) begin
        rd_data <= rx_shift;
      end
    end
  end

  assign state_code = state;
  assign debug_out  = {state_code, 2'b00, quarter, bit_cnt, 4'h0, addr_lat, rd_data};

endmodule

// File: tb/tb_sccb_reader.sv
// ---------------------------------------------------------------------------
// tb_sccb_reader
//   Scoreboard bench for sccb_reader. Two instances share one behavioural
//   SCCB slave (ID 0x21, reg 0x0A = 0x76, reg 0x0B = 0x73) through a bus
//   select: dut32 (CLK_DIV = 32) and dut4 (CLK_DIV = 4). Stimulus pushes the
//   expected {rd_data, err, latency} per request, and a monitor per DUT pops
//   and compares on every done pulse. The slave logs the bus as a trace:
//   256 = START, 257 = STOP, 0..255 = byte, 512 + bit = 9th (ACK/NACK) bit.
// ---------------------------------------------------------------------------
module tb_sccb_reader;

  logic        clk;
  logic        rst;
  logic        start32;
  logic        start4;
  logic        dev_sel;
  logic [6:0]  dev_id;
  logic [7:0]  reg_addr;

  logic        busy32, done32, err32, scl32;
  logic [7:0]  rd32;
  logic [31:0] dbg32;
  logic        busy4, done4, err4, scl4;
  logic [7:0]  rd4;
  logic [31:0] dbg4;
  wire         sda32;
  wire         sda4;

  logic        sel;     // 0: slave on dut32 bus, 1: slave on dut4 bus
  logic        s_en;    // slave present
  logic        s_low;

  pullup (sda32);
  pullup (sda4);
  assign sda32 = (s_low && !sel && !rst) ? 1'b0 : 1'bz;
  assign sda4  = (s_low &&  sel && !rst) ? 1'b0 : 1'bz;

  wire mscl = sel ? scl4 : scl32;
  wire msda = sel ? sda4 : sda32;

  sccb_reader #(.CLK_DIV(32), .DEV_ID(7'h21)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .dev_sel(dev_sel), .dev_id(dev_id),
    .reg_addr(reg_addr), .busy(busy32), .done(done32), .err(err32),
    .rd_data(rd32), .scl(scl32), .sda(sda32), .debug_out(dbg32)
  );

  sccb_reader #(.CLK_DIV(4), .DEV_ID(7'h21)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dev_sel(dev_sel), .dev_id(dev_id),
    .reg_addr(reg_addr), .busy(busy4), .done(done4), .err(err4),
    .rd_data(rd4), .scl(scl4), .sda(sda4), .debug_out(dbg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int rd;
    int er;
    int lat;
    int t0;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  logic done32_d = 1'b0;
  logic done4_d  = 1'b0;

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      if (done32_d) begin
        n_cmp++; n_bad++;
        $display("FAIL done32_width: done high for more than one cycle");
      end else if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done32_unexpected: done pulse with no request pending");
      end else begin
        e = q32.pop_front();
        check("rd_data32", rd32, e.rd);
        check("err32", err32, e.er);
        check("latency32", cyc - e.t0, e.lat);
        check("busy32_at_done", busy32, 0);
      end
    end
    done32_d <= done32;
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      if (done4_d) begin
        n_cmp++; n_bad++;
        $display("FAIL done4_width: done high for more than one cycle");
      end else if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done4_unexpected: done pulse with no request pending");
      end else begin
        e = q4.pop_front();
        check("rd_data4", rd4, e.rd);
        check("err4", err4, e.er);
        check("latency4", cyc - e.t0, e.lat);
      end
    end
    done4_d <= done4;
  end

  // ---------------- SCL run lengths on dut4 ----------------
  logic scl4_prev = 1'b1;
  int   run4 = 0;
  logic rec4 = 1'b0;
  int   hi4[$];
  int   lo4[$];

  always @(negedge clk) begin
    if (scl4 == scl4_prev) begin
      run4 <= run4 + 1;
    end else begin
      if (rec4) begin
        if (scl4_prev) hi4.push_back(run4);
        else           lo4.push_back(run4);
      end
      run4 <= 1;
    end
    scl4_prev <= scl4;
  end

  // ---------------- behavioural slave ----------------
  int         tr[$];
  int         tr_exp[$];
  int         s_cnt = 0;
  int         s_idx = 0;
  logic       s_rd  = 1'b0;
  logic       s_ok  = 1'b0;
  logic       s_rnw = 1'b0;
  logic [7:0] s_sh  = 8'h00;
  logic [7:0] s_ptr = 8'h00;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    case (a)
      8'h0A:   return 8'h76;
      8'h0B:   return 8'h73;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin : slave
    int c;
    int ix;
    logic rd, ok, rnw, lo;
    logic [7:0] sh, ptr, data;
    c = s_cnt; ix = s_idx; rd = s_rd; ok = s_ok; rnw = s_rnw;
    lo = s_low; sh = s_sh; ptr = s_ptr;
    if (rst) begin
      c = 0; ix = 0; rd = 1'b0; ok = 1'b0; lo = 1'b0;
    end else if (p_scl && mscl && p_sda && !msda) begin
      tr.push_back(256);
      c = 0; ix = 0; rd = 1'b0; lo = 1'b0;
    end else if (p_scl && mscl && !p_sda && msda) begin
      tr.push_back(257);
      c = 0; rd = 1'b0; lo = 1'b0;
    end else if (!p_scl && mscl) begin
      c++;
      if (c <= 8) sh = {sh[6:0], msda};
      if (c == 8) begin
        tr.push_back(int'(sh));
        if (ix == 0) begin
          ok  = s_en && (sh[7:1] == 7'h21);
          rnw = sh[0];
        end else if (ix == 1 && !rd && ok) begin
          ptr = sh;
        end
      end
      if (c == 9) begin
        tr.push_back(512 + int'(msda));
        rd = 1'b0;
      end
    end else if (p_scl && !mscl) begin
      if (c == 9) begin
        c = 0;
        ix++;
        if (ix == 1 && rnw && ok) rd = 1'b1;
      end
      if (c == 8) begin
        lo = ok && !rd;
      end else if (rd && c < 8) begin
        data = mem_rd(ptr);
        lo = !data[7-c];
      end else begin
        lo = 1'b0;
      end
    end
    s_cnt <= c; s_idx <= ix; s_rd <= rd; s_ok <= ok; s_rnw <= rnw;
    s_low <= lo; s_sh <= sh; s_ptr <= ptr;
    p_scl <= mscl; p_sda <= msda;
  end

  // ---------------- stimulus helpers ----------------
  task automatic build_exp(input int sub, input int data, input int ack, input bit full);
    tr_exp.delete();
    tr_exp.push_back(256); tr_exp.push_back('h42); tr_exp.push_back(512 + ack);
    if (full) begin
      tr_exp.push_back(sub);  tr_exp.push_back(512 + ack); tr_exp.push_back(257);
      tr_exp.push_back(256);  tr_exp.push_back('h43);      tr_exp.push_back(512 + ack);
      tr_exp.push_back(data); tr_exp.push_back(513);       tr_exp.push_back(257);
    end else begin
      tr_exp.push_back(257);
    end
  endtask

  task automatic cmp_trace(input string nm);
    check({nm, "_len"}, tr.size(), tr_exp.size());
    for (int i = 0; i < tr_exp.size(); i++) begin
      check($sformatf("%s[%0d]", nm, i), (i < tr.size()) ? tr[i] : -1, tr_exp[i]);
    end
  endtask

  // Pulse start on the chosen DUT; optionally enqueue the expected result.
  task automatic issue(input bit on4, input bit ds, input logic [6:0] id,
                       input logic [7:0] addr, input int erd, input int eer,
                       input int elat, input bit push);
    exp_t e;
    @(posedge clk); #1;
    dev_sel = ds; dev_id = id; reg_addr = addr;
    if (on4) start4 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start32 = 1'b0;
    check(on4 ? "busy4_after_accept" : "busy32_after_accept", on4 ? busy4 : busy32, 1);
    e.rd = erd; e.er = eer; e.lat = elat; e.t0 = cyc;
    if (push) begin
      if (on4) q4.push_back(e); else q32.push_back(e);
    end
  endtask

  task automatic wait_drain(input bit on4, input int maxc);
    int n;
    n = 0;
    while (((on4 ? q4.size() : q32.size()) != 0) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(on4 ? "drain4" : "drain32", on4 ? q4.size() : q32.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start32 = 1'b0; start4 = 1'b0; dev_sel = 1'b0;
    dev_id = 7'h00; reg_addr = 8'h00; sel = 1'b0; s_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_err", err32, 0);
    check("rst_rd_data", rd32, 0);
    check("rst_scl", scl32, 1);
    check("rst_sda", sda32, 1);
    check("rst_scl4", scl4, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain read of 0x0A through the default ID
    tr.delete();
    build_exp('h0A, 'h76, 0, 1'b1);
    issue(1'b0, 1'b0, 7'h00, 8'h0A, 'h76, 0, 5248, 1'b1);
    wait_drain(1'b0, 6000);
    cmp_trace("trace_basic");
    check("debug32", dbg32, 32'h0000_0A76);

    // Fast instance: reg 0x0B, SCL high/low time
    sel = 1'b1;
    repeat (2) @(posedge clk);
    hi4.delete(); lo4.delete(); rec4 = 1'b1;
    issue(1'b1, 1'b0, 7'h00, 8'h0B, 'h73, 0, 656, 1'b1);
    wait_drain(1'b1, 1000);
    rec4 = 1'b0;
    check("scl4_high", (hi4.size() > 1) ? hi4[1] : -1, 8);
    check("scl4_low", (lo4.size() > 1) ? lo4[1] : -1, 8);
    check("debug4", dbg4, 32'h0000_0B73);
    sel = 1'b0;
    repeat (2) @(posedge clk);

    // Re-pulse start 100 cycles in: ignored, single done, same trace
    tr.delete();
    build_exp('h0A, 'h76, 0, 1'b1);
    issue(1'b0, 1'b0, 7'h00, 8'h0A, 'h76, 0, 5248, 1'b1);
    repeat (98) @(posedge clk);
    #1 start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    wait_drain(1'b0, 6000);
    repeat (20) @(posedge clk);
    cmp_trace("trace_repulse");

    // Reset in the middle of TX_SUB
    issue(1'b0, 1'b0, 7'h00, 8'h0B, 0, 0, 0, 1'b0);
    repeat (1998) @(posedge clk);
    #1;
    check("pre_rst_busy", busy32, 1);
    rst = 1'b1;
    #1;
    check("midrst_scl", scl32, 1);
    check("midrst_sda", sda32, 1);
    check("midrst_busy", busy32, 0);
    check("midrst_rd_data", rd32, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    tr.delete();
    build_exp('h0B, 'h73, 0, 1'b1);
    issue(1'b0, 1'b1, 7'h21, 8'h0B, 'h73, 0, 5248, 1'b1);
    wait_drain(1'b0, 6000);
    cmp_trace("trace_after_rst");

    // No slave on the bus: SDA stays pulled up
    s_en = 1'b0;
    tr.delete();
`ifdef SCCB_ACK_CHECK_EN
    build_exp(0, 0, 1, 1'b0);
    issue(1'b0, 1'b0, 7'h00, 8'h0A, 'h73, 1, 1408, 1'b1);
`else
    tr_exp.delete();
    tr_exp.push_back(256); tr_exp.push_back('h42); tr_exp.push_back(513);
    tr_exp.push_back('h0A); tr_exp.push_back(513); tr_exp.push_back(257);
    tr_exp.push_back(256); tr_exp.push_back('h43); tr_exp.push_back(513);
    tr_exp.push_back('hFF); tr_exp.push_back(513); tr_exp.push_back(257);
    issue(1'b0, 1'b0, 7'h00, 8'h0A, 'hFF, 0, 5248, 1'b1);
`endif
    wait_drain(1'b0, 6000);
    cmp_trace("trace_noslave");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
